// File: rtl/sequence_game_core.sv
// Simon-style sequence game engine: grows a pseudo-random symbol sequence, replays it
// as timed prompts, then checks the player's channel toggles against it.
module sequence_game_core #(
  parameter int          NUM_CH     = 4,
  parameter int          MAX_LEN    = 16,
  parameter int          SHOW_TICKS = 25000000,
  parameter int          GAP_TICKS  = 12500000,
  parameter int          INPUT_TMO  = 0,
  parameter int          LIVES_INIT = 3,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         CH_W       = $clog2(NUM_CH + 1),
  localparam int         LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic [NUM_CH-1:0]  ch_in,
  output logic [CH_W-1:0]    prompt,
  output logic               showing,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic [LEN_W-1:0]   level,
  output logic               game_over,
  output logic               won
);

  localparam int SYM_W  = $clog2(NUM_CH);
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int T_MAX1 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int T_MAX  = (INPUT_TMO > T_MAX1) ? INPUT_TMO : T_MAX1;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_TICKS - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_TICKS - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'((INPUT_TMO > 0) ? INPUT_TMO - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_EXTEND, S_SHOW, S_INPUT, S_ROUND_OK, S_MISS, S_LOSE, S_WIN
  } state_t;

  state_t              state_q, state_d;
  logic                go_meta_q, go_meta_d, go_sync_q, go_sync_d, go_prev_q, go_prev_d;
  logic [NUM_CH-1:0]   ch_meta_q, ch_meta_d, ch_sync_q, ch_sync_d, ch_prev_q, ch_prev_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]    tick_q, tick_d;
  logic                gap_q, gap_d;
  logic [CH_W-1:0]     prompt_q, prompt_d;
  logic                showing_q, showing_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          lives_q, lives_d;
  logic [LEN_W-1:0]    level_q, level_d;
  logic                game_over_q, game_over_d;
  logic                won_q, won_d;

  logic [SYM_W-1:0]    mem_q [2**IDX_W];
  logic                mem_we;

  logic [SYM_W-1:0]    new_sym, cur_sym, next_sym, first_sym;
  logic [LEN_W-1:0]    idx_inc, level_last;
  logic [NUM_CH-1:0]   ev, want;
  logic                ev_any, ev_multi, ev_hit, go_rise;

  function automatic logic [CH_W-1:0] to_prompt(input logic [SYM_W-1:0] s);
    return CH_W'(s) + CH_W'(1);
  endfunction

  always_comb begin
    go_meta_d = go;
    go_sync_d = go_meta_q;
    go_prev_d = go_sync_q;
    ch_meta_d = ch_in;
    ch_sync_d = ch_meta_q;
    ch_prev_d = ch_sync_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // An event is a one-cycle difference between successive synced levels.
  always_comb begin
    new_sym    = SYM_W'(lfsr_q[7:0] % 8'(NUM_CH));
    idx_inc    = idx_q + LEN_W'(1);
    level_last = level_q - LEN_W'(1);
    cur_sym    = mem_q[idx_q[IDX_W-1:0]];
    next_sym   = mem_q[idx_inc[IDX_W-1:0]];
    first_sym  = mem_q[IDX_ZERO];
    ev         = ch_sync_q ^ ch_prev_q;
    ev_any     = |ev;
    ev_multi   = |(ev & (ev - NUM_CH'(1)));
    want       = NUM_CH'(1) << cur_sym;
    ev_hit     = ev_any && !ev_multi && (ev == want);
    go_rise    = go_sync_q && !go_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tick_d      = tick_q;
    gap_d       = gap_q;
    prompt_d    = prompt_q;
    showing_d   = showing_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    game_over_d = game_over_q;
    won_d       = won_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_sync_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (!go_sync_q) begin
          score_d = '0;
          level_d = '0;
          lives_d = 4'(LIVES_INIT);
          state_d = S_EXTEND;
        end
      end
      S_EXTEND: begin
        // The symbol written this cycle is bypassed when it is also the first prompt.
        mem_we    = 1'b1;
        level_d   = level_q + LEN_W'(1);
        idx_d     = '0;
        tick_d    = '0;
        gap_d     = 1'b0;
        showing_d = 1'b1;
        prompt_d  = to_prompt((level_q == '0) ? new_sym : first_sym);
        state_d   = S_SHOW;
      end
      S_SHOW: begin
        if (!gap_q) begin
          if (tick_q == SHOW_LAST) begin
            gap_d    = 1'b1;
            tick_d   = '0;
            prompt_d = '0;
          end else begin
            tick_d = tick_q + TMR_W'(1);
          end
        end else if (tick_q == GAP_LAST) begin
          tick_d = '0;
          gap_d  = 1'b0;
          if (idx_q == level_last) begin
            idx_d     = '0;
            showing_d = 1'b0;
            state_d   = S_INPUT;
          end else begin
            idx_d    = idx_inc;
            prompt_d = to_prompt(next_sym);
          end
        end else begin
          tick_d = tick_q + TMR_W'(1);
        end
      end
      S_INPUT: begin
        if (ev_any) begin
          if (ev_hit) begin
            tick_d = '0;
            if (idx_q == level_last) begin
              idx_d   = '0;
              state_d = S_ROUND_OK;
            end else begin
              idx_d = idx_inc;
            end
          end else begin
            state_d = S_MISS;
          end
        end else if (INPUT_TMO > 0 && tick_q == TMO_LAST) begin
          state_d = S_MISS;
        end else begin
          tick_d = tick_q + TMR_W'(1);
        end
      end
      S_ROUND_OK: begin
        if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
        if (level_q == LEN_W'(MAX_LEN)) begin
          game_over_d = 1'b1;
          won_d       = 1'b1;
          state_d     = S_WIN;
        end else begin
          state_d = S_EXTEND;
        end
      end
      S_MISS: begin
        // A surviving miss replays the unchanged sequence from the start.
        lives_d = lives_q - 4'd1;
        if (lives_q == 4'd1) begin
          game_over_d = 1'b1;
          state_d     = S_LOSE;
        end else begin
          idx_d     = '0;
          tick_d    = '0;
          gap_d     = 1'b0;
          showing_d = 1'b1;
          prompt_d  = to_prompt(first_sym);
          state_d   = S_SHOW;
        end
      end
      S_LOSE, S_WIN: begin
        if (go_rise) begin
          game_over_d = 1'b0;
          won_d       = 1'b0;
          state_d     = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      go_meta_q   <= 1'b0;
      go_sync_q   <= 1'b0;
      go_prev_q   <= 1'b0;
      ch_meta_q   <= '0;
      ch_sync_q   <= '0;
      ch_prev_q   <= '0;
      lfsr_q      <= SEED;
      idx_q       <= '0;
      tick_q      <= '0;
      gap_q       <= 1'b0;
      prompt_q    <= '0;
      showing_q   <= 1'b0;
      score_q     <= '0;
      lives_q     <= 4'(LIVES_INIT);
      level_q     <= '0;
      game_over_q <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_meta_q   <= go_meta_d;
      go_sync_q   <= go_sync_d;
      go_prev_q   <= go_prev_d;
      ch_meta_q   <= ch_meta_d;
      ch_sync_q   <= ch_sync_d;
      ch_prev_q   <= ch_prev_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      gap_q       <= gap_d;
      prompt_q    <= prompt_d;
      showing_q   <= showing_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      game_over_q <= game_over_d;
      won_q       <= won_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[level_q[IDX_W-1:0]] <= new_sym;
  end

  assign prompt    = prompt_q;
  assign showing   = showing_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign game_over = game_over_q;
  assign won       = won_q;

endmodule

// File: tb/tb_sequence_game_core.sv
// Scoreboard bench for sequence_game_core: stimulus queues expected status and display
// episodes; negedge monitors pop and compare whenever the DUT changes or finishes a display.
module tb_sequence_game_core;

  logic       clock = 1'b0;
  logic       reset;
  logic       go;
  logic [3:0] ch_in;
  logic [2:0] prompt;
  logic       showing;
  logic [7:0] score;
  logic [3:0] lives;
  logic [1:0] level;
  logic       game_over;
  logic       won;

  sequence_game_core #(
    .NUM_CH(4), .MAX_LEN(3), .SHOW_TICKS(4), .GAP_TICKS(2),
    .INPUT_TMO(20), .LIVES_INIT(2), .SCORE_W(8), .SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .ch_in(ch_in),
    .prompt(prompt), .showing(showing), .score(score), .lives(lives),
    .level(level), .game_over(game_over), .won(won)
  );

  always #5 clock = ~clock;

  typedef struct packed { int len; int nknown; } show_exp_t;

  int        checks = 0;
  int        failures = 0;
  int        status_q[$];
  show_exp_t show_q[$];
  int        model_seq[4];
  int        seen[4];
  int        cap[64];
  int        cap_n = 0;
  int        shows_done = 0;
  int        prev_st = 0;
  bit        mon_en = 1'b0;
  bit        prev_showing = 1'b0;
  int        since_fall = 0;
  int        lives_lat = -1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int pack_st(input int s, input int l, input int lv, input int g, input int w);
    return (s << 8) | (l << 4) | (lv << 2) | (g << 1) | w;
  endfunction

  // Status monitor: every change of {score,lives,level,game_over,won} must match the next expectation.
  always @(negedge clock) begin
    int cur;
    cur = pack_st(int'(score), int'(lives), int'(level), int'(game_over), int'(won));
    if (prev_showing && !showing) since_fall = 0;
    else since_fall++;
    prev_showing = showing;
    if (mon_en && cur != prev_st) begin
      if (int'(lives) != ((prev_st >> 4) & 15)) lives_lat = since_fall;
      if (status_q.size() == 0) checkOutput("status_unexpected", cur, prev_st);
      else checkOutput("status", cur, status_q.pop_front());
    end
    prev_st = cur;
  end

  // Display monitor: collects prompt values while showing is high and judges the episode when it ends.
  always @(negedge clock) begin
    if (showing) begin
      if (cap_n < 64) cap[cap_n] = int'(prompt);
      cap_n++;
    end else if (cap_n != 0) begin
      if (show_q.size() == 0) begin
        checkOutput("show_unexpected_cycles", cap_n, 0);
      end else begin
        show_exp_t e;
        bit shape_ok;
        e = show_q.pop_front();
        checkOutput("show_cycles", cap_n, e.len * 6);
        shape_ok = 1'b1;
        for (int i = 0; i < e.len && i < 4 && (i * 6 + 5) < cap_n; i++) begin
          for (int j = 0; j < 4; j++)
            if (cap[i*6+j] != cap[i*6] || cap[i*6] < 1 || cap[i*6] > 4) shape_ok = 1'b0;
          if (cap[i*6+4] != 0 || cap[i*6+5] != 0) shape_ok = 1'b0;
          seen[i] = cap[i*6];
        end
        checkOutput("show_shape", int'(shape_ok), 1);
        for (int i = 0; i < e.nknown; i++) checkOutput("show_replay_symbol", seen[i], model_seq[i]);
      end
      shows_done++;
      cap_n = 0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [3:0] flip);
    @(negedge clock);
    ch_in = ch_in ^ flip;
  endtask

  task automatic push_status(input int s, input int l, input int lv, input int g, input int w);
    status_q.push_back(pack_st(s, l, lv, g, w));
  endtask

  task automatic push_show(input int len, input int nknown);
    show_exp_t e;
    e.len = len;
    e.nknown = nknown;
    show_q.push_back(e);
  endtask

  task automatic wait_show(input int target);
    int n = 0;
    while (shows_done < target && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (shows_done < target) checkOutput("show_wait", shows_done, target);
  endtask

  task automatic wait_status_drained();
    int n = 0;
    while (status_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (status_q.size() != 0) checkOutput("status_wait_pending", status_q.size(), 0);
  endtask

  task automatic take_seq(input int n);
    for (int i = 0; i < n; i++) model_seq[i] = seen[i];
  endtask

  task automatic pulse_go();
    @(negedge clock);
    go = 1'b1;
    wait_cycles(3);
    go = 1'b0;
  endtask

  task automatic echo(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(4'(1 << (model_seq[i] - 1)));
      wait_cycles(2);
    end
  endtask

  function automatic logic [3:0] wrong_ch(input int p);
    return 4'(1 << (p % 4));
  endfunction

  initial begin
    reset = 1'b0;
    go    = 1'b0;
    ch_in = 4'b0000;
    wait_cycles(3);
    checkOutput("rst_prompt", int'(prompt), 0);
    checkOutput("rst_showing", int'(showing), 0);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_lives", int'(lives), 2);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_game_over", int'(game_over), 0);
    checkOutput("rst_won", int'(won), 0);
    reset = 1'b1;
    wait_cycles(2);
    mon_en = 1'b1;

    $display("[TB] game A: start, display and full win");
    push_status(0, 2, 1, 0, 0);
    push_show(1, 0);
    pulse_go();
    wait_show(1);
    take_seq(1);
    push_status(1, 2, 1, 0, 0);
    push_status(1, 2, 2, 0, 0);
    push_show(2, 1);
    echo(1);
    wait_show(2);
    take_seq(2);
    push_status(2, 2, 2, 0, 0);
    push_status(2, 2, 3, 0, 0);
    push_show(3, 2);
    echo(2);
    wait_show(3);
    take_seq(3);
    push_status(3, 2, 3, 1, 1);
    echo(3);
    wait_status_drained();

    $display("[TB] game B: wrong entries until game over");
    push_status(3, 2, 3, 0, 0);
    push_status(0, 2, 0, 0, 0);
    push_status(0, 2, 1, 0, 0);
    push_show(1, 0);
    pulse_go();
    wait_show(4);
    take_seq(1);
    push_status(0, 1, 1, 0, 0);
    push_show(1, 1);
    applyStimulus(wrong_ch(model_seq[0]));
    wait_show(5);
    push_status(0, 0, 1, 1, 0);
    applyStimulus(wrong_ch(model_seq[0]));
    wait_status_drained();

    $display("[TB] game C: entry timeout, then simultaneous channels");
    push_status(0, 0, 1, 0, 0);
    push_status(0, 2, 0, 0, 0);
    push_status(0, 2, 1, 0, 0);
    push_show(1, 0);
    pulse_go();
    wait_show(6);
    take_seq(1);
    push_status(0, 1, 1, 0, 0);
    push_show(1, 1);
    wait_status_drained();
    checkOutput("timeout_latency", lives_lat, 21);
    wait_show(7);
    push_status(0, 0, 1, 1, 0);
    applyStimulus(4'b0011);
    wait_status_drained();

    $display("[TB] game D: toggles during display, then reset mid-entry");
    push_status(0, 0, 1, 0, 0);
    push_status(0, 2, 0, 0, 0);
    push_status(0, 2, 1, 0, 0);
    push_show(1, 0);
    pulse_go();
    begin
      int n = 0;
      while (!showing && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (!showing) checkOutput("showing_wait", int'(showing), 1);
    end
    applyStimulus(4'b1111);
    applyStimulus(4'b0100);
    wait_show(8);
    take_seq(1);
    push_status(1, 2, 1, 0, 0);
    push_status(1, 2, 2, 0, 0);
    push_show(2, 1);
    echo(1);
    wait_show(9);
    take_seq(2);
    applyStimulus(4'(1 << (model_seq[0] - 1)));
    wait_cycles(3);
    wait_status_drained();
    push_status(0, 2, 0, 0, 0);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_prompt", int'(prompt), 0);
    checkOutput("midrst_showing", int'(showing), 0);
    checkOutput("midrst_score", int'(score), 0);
    checkOutput("midrst_lives", int'(lives), 2);
    checkOutput("midrst_level", int'(level), 0);
    checkOutput("midrst_game_over", int'(game_over), 0);
    checkOutput("midrst_won", int'(won), 0);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(6);
    checkOutput("status_queue_left", status_q.size(), 0);
    checkOutput("show_queue_left", show_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
